instr_prefetch_buffer: RTL and testbench
========================================

# instr_prefetch_buffer

Parametrised instruction fetch front-end that replaces the combinational instruction-memory interface in the IF stage. Issues word-aligned fetches on the gnt/rvalid instruction bus with up to NUM_OUTSTANDING requests in flight. Buffers responses in a DEPTH-entry FIFO. Discards stale responses after a branch/redirect. Presents one instruction per cycle to the IF/ID register with a valid/ready handshake.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- NUM_OUTSTANDING, 2: maximum granted-but-unanswered requests; 1 to DEPTH.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- boot_addr_i  in  32  fetch start address; sampled every cycle while rst_i=1.
- fetch_en_i  in  1  allow new requests to be issued.
- branch_i  in  1  redirect request; single-cycle pulse.
- branch_addr_i  in  32  redirect target; bits [1:0] ignored (forced to 00).
- valid_o  out  1  head-of-FIFO instruction valid.
- ready_i  in  1  consumer accepts the head entry when valid_o & ready_i.
- rdata_o  out  32  instruction word.
- addr_o  out  32  address of rdata_o.
- err_o  out  1  bus error recorded for this entry.
- instr_req_o  out  1  bus request.
- instr_gnt_i  in  1  bus grant.
- instr_addr_o  out  32  request address.
- instr_rvalid_i  in  1  response valid.
- instr_rdata_i  in  32  response data.
- instr_err_i  in  1  response error.

## Operation
- **Fetch address register (faddr):**
  - Loaded with {boot_addr_i[31:2],2'b00} during reset.
  - +4 on each grant (instr_req_o & instr_gnt_i).
  - Loaded with the aligned branch_addr_i on branch_i.
- **Issue condition:** fetch_en_i & (outstanding < NUM_OUTSTANDING) & (fifo_count + outstanding < DEPTH). Credit-based, so a response always has a free slot.
- **Bus stability:** once instr_req_o=1 and no grant has arrived, instr_req_o and instr_addr_o hold stable until the grant, even if branch_i or fetch_en_i=0 occurs.
  - A branch during an ungranted request is recorded as pending.
  - On the grant, faddr takes the branch target instead of +4, and the granted request is marked stale.
- **Outstanding counter:** +1 on grant, -1 on rvalid; both in the same cycle means no change.
- **Discard counter:**
  - On branch_i it is loaded with outstanding, adjusted for the same-cycle grant/rvalid.
  - Incremented on grant of a request that was pending when the branch arrived.
  - While it is non-zero, each rvalid decrements it and the response is dropped, never written to the FIFO.
- **FIFO:**
  - Each entry holds {addr, rdata, err}; addr comes from an internal address queue that advances on each accepted response.
  - branch_i empties the FIFO in that cycle; a same-cycle pop is ignored.
- **Responses with err:** stored like normal entries; fetching continues.

## Timing
- **Reset values:**
  - instr_req_o=0, valid_o=0, rdata_o=0, addr_o=0, err_o=0.
  - instr_addr_o=aligned boot_addr_i.
  - outstanding=0, discard=0, FIFO empty.
- **First request:** the first cycle after rst_i falls with fetch_en_i=1.
- **Normal latency:** rvalid in cycle M → valid_o=1 in cycle M+1.
- **Redirect:** branch_i in cycle N (no ungranted request pending) → instr_req_o=1, instr_addr_o=target in cycle N+1. valid_o=0 in N+1.
- **Throughput:** with zero-wait gnt and 1-cycle rvalid, one instruction per cycle sustained when NUM_OUTSTANDING≥2.
- **Full:** when fifo_count+outstanding=DEPTH, instr_req_o stays 0 until a pop.
- **Pointer wrap:** read/write pointers are log2(DEPTH)+1 bits with natural wrap.
- **Simultaneous push and pop when full:** permitted; the pop frees the slot the credit reserved.

## Configuration
- PREFETCH_BYPASS_EN defined:
  - When the FIFO is empty and a non-discarded rvalid arrives, valid_o/rdata_o/addr_o/err_o are driven combinationally in the same cycle.
  - If ready_i=1 that cycle, the entry is not written.
  - Latency becomes 0 cycles from rvalid.
- Undefined: always registered, 1-cycle latency as above.

## Structure
- **Package prefetch_pkg:** fetch_entry_t struct {addr[31:0], rdata[31:0], err}; constant ALIGN_MASK=32'hFFFF_FFFC.
- **Sub-module prefetch_fifo:** parametrised DEPTH, storing fetch_entry_t. Ports: push, pop, flush, count, full, empty.
- **Top level:** the request FSM and the outstanding/discard counters.
- **Request FSM states:**
  - IDLE: no request.
  - REQ: req asserted, waiting for grant.
  - REQ_STALE: req asserted, branch pending.
  - Transitions: IDLE→REQ on the issue condition. REQ→IDLE or REQ on grant. REQ→REQ_STALE on branch without grant. REQ_STALE→IDLE/REQ on grant.

## Test plan
- **Reset and boot:** boot_addr_i=0x80 with rst_i high, release, fetch_en_i=1, gnt always 1, rvalid one cycle later → instr_addr_o sequence 0x80, 0x84, 0x88. valid_o in order with addr_o matching.
- **Back-pressure:** DEPTH=4, ready_i=0 → exactly 4 grants, then instr_req_o=0. Raise ready_i → one pop per cycle, requests resume.
- **Branch with 2 outstanding:** branch_addr_i=0x203 → FIFO empties. The two old responses are dropped. The next request goes to 0x200 and the first valid_o has addr_o=0x200.
- **Branch while gnt=0:** instr_addr_o stays 0x84 until grant. Its response is dropped. The next request goes to the target.
- **Bus error:** instr_err_i=1 on the response for 0x88 → that entry has err_o=1, the neighbouring entries have err_o=0.
- **Bypass (PREFETCH_BYPASS_EN):** with the FIFO empty, rvalid and ready_i in the same cycle → valid_o=1 in that cycle and FIFO count remains 0.

Source files
------------

// File: rtl/prefetch_pkg.sv
// Shared types for the instruction prefetch buffer: FIFO entry layout,
// address alignment mask and the request FSM encoding.
package prefetch_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] rdata;
      logic        err;
   } fetch_entry_t;

   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_REQ_STALE
   } req_state_e;

endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH-entry FIFO of fetch entries. Pointers carry one extra wrap bit so
// full and empty are distinguished; flush drops everything in one cycle.
module prefetch_fifo
   import prefetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  fetch_entry_t             wdata_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output fetch_entry_t             rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   fetch_entry_t mem_q [DEPTH];

   assign count_o = wptr_q - rptr_q;
   assign full_o  = (count_o == (AW+1)'(DEPTH));
   assign empty_o = (wptr_q == rptr_q);
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush_i) begin
         rptr_d = wptr_q;
      end else begin
         if (push_i)
            wptr_d = wptr_q + 1'b1;
         if (pop_i && !empty_o)
            rptr_d = rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i)
         mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch front-end: credit-limited request issue, stale-response
// discard after redirects, and a valid/ready instruction output.
// Optional macro PREFETCH_BYPASS_EN: forward a response straight to the output when the FIFO is empty.
module instr_prefetch_buffer
   import prefetch_pkg::*;
#(
   parameter int DEPTH           = 4,
   parameter int NUM_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] boot_addr_i,
   input  logic        fetch_en_i,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] rdata_o,
   output logic [31:0] addr_o,
   output logic        err_o,
   output logic        instr_req_o,
   input  logic        instr_gnt_i,
   output logic [31:0] instr_addr_o,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i
);
   localparam int CW = $clog2(DEPTH) + 1;

   req_state_e    state_q, state_d;
   logic [31:0]   faddr_q, faddr_d, btgt_q, btgt_d, raddr_q, raddr_d;
   logic [CW-1:0] outst_q, outst_d, disc_q, disc_d;
   logic [CW-1:0] fifo_count;
   logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
   fetch_entry_t  fifo_head, rsp_entry, out_entry;
   logic [31:0]   boot_aligned, branch_tgt;
   logic          credit_ok, issue, grant, rsp_drop, rsp_take, bypass, out_vld;

   assign boot_aligned = boot_addr_i & ALIGN_MASK;
   assign branch_tgt   = branch_addr_i & ALIGN_MASK;

   // Every in-flight request already owns a FIFO slot, so responses never overflow.
   assign credit_ok = !fifo_full && (outst_q < CW'(NUM_OUTSTANDING)) &&
                      (({1'b0, fifo_count} + {1'b0, outst_q}) < (CW+1)'(DEPTH));
   assign issue        = fetch_en_i && !branch_i && credit_ok;
   assign instr_req_o  = !rst_i && ((state_q != S_IDLE) || issue);
   assign instr_addr_o = rst_i ? boot_aligned : faddr_q;
   assign grant        = instr_req_o && instr_gnt_i;

   assign rsp_drop  = (disc_q != '0);
   assign rsp_take  = !rst_i && instr_rvalid_i && !rsp_drop && !branch_i;
   assign rsp_entry = '{addr: raddr_q, rdata: instr_rdata_i, err: instr_err_i};

`ifdef PREFETCH_BYPASS_EN
   assign bypass = fifo_empty && rsp_take;
`else
   assign bypass = 1'b0;
`endif

   assign fifo_push = rsp_take && !(bypass && ready_i);
   assign fifo_pop  = !fifo_empty && ready_i && !branch_i;
   assign out_vld   = !fifo_empty || bypass;
   assign out_entry = fifo_empty ? rsp_entry : fifo_head;

   assign valid_o = out_vld;
   assign rdata_o = out_vld ? out_entry.rdata : '0;
   assign addr_o  = out_vld ? out_entry.addr  : '0;
   assign err_o   = out_vld && out_entry.err;

   always_comb begin
      state_d = state_q;
      faddr_d = faddr_q;
      btgt_d  = btgt_q;
      raddr_d = raddr_q;
      outst_d = outst_q + CW'(grant) - CW'(instr_rvalid_i);
      disc_d  = disc_q;

      unique case (state_q)
         S_IDLE:      if (issue && !instr_gnt_i) state_d = S_REQ;
         S_REQ:       if (instr_gnt_i) state_d = S_IDLE;
                      else if (branch_i) state_d = S_REQ_STALE;
         S_REQ_STALE: if (instr_gnt_i) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase

      // A held request must keep its address; the target waits in btgt_q.
      if (branch_i && !((state_q != S_IDLE) && !instr_gnt_i))
         faddr_d = branch_tgt;
      else if (grant)
         faddr_d = (state_q == S_REQ_STALE) ? btgt_q : faddr_q + 32'd4;

      if (branch_i) begin
         btgt_d  = branch_tgt;
         raddr_d = branch_tgt;
         disc_d  = outst_d;
      end else begin
         if (rsp_take)
            raddr_d = raddr_q + 32'd4;
         disc_d = disc_q - CW'(instr_rvalid_i && rsp_drop)
                         + CW'(grant && (state_q == S_REQ_STALE));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         faddr_q <= boot_aligned;
         btgt_q  <= boot_aligned;
         raddr_q <= boot_aligned;
         outst_q <= '0;
         disc_q  <= '0;
      end else begin
         state_q <= state_d;
         faddr_q <= faddr_d;
         btgt_q  <= btgt_d;
         raddr_q <= raddr_d;
         outst_q <= outst_d;
         disc_q  <= disc_d;
      end
   end

   prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .wdata_i (rsp_entry),
      .pop_i   (fifo_pop),
      .flush_i (branch_i),
      .rdata_o (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: directed scenarios plus random bus traffic
// against an in-order stream model (honours PREFETCH_BYPASS_EN).
module tb_instr_prefetch_buffer;
   localparam int DEPTH   = 4;
   localparam int NUM_OUT = 2;
`ifdef PREFETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i, fetch_en_i, branch_i, ready_i;
   logic [31:0] boot_addr_i, branch_addr_i;
   logic        valid_o, err_o, instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i;
   logic [31:0] rdata_o, addr_o, instr_addr_o, instr_rdata_i;

   instr_prefetch_buffer #(.DEPTH(DEPTH), .NUM_OUTSTANDING(NUM_OUT)) dut (
      .clk_i(clk), .rst_i(rst_i), .boot_addr_i(boot_addr_i), .fetch_en_i(fetch_en_i),
      .branch_i(branch_i), .branch_addr_i(branch_addr_i), .valid_o(valid_o),
      .ready_i(ready_i), .rdata_o(rdata_o), .addr_o(addr_o), .err_o(err_o),
      .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
      .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i)
   );

   typedef struct { logic [31:0] addr; bit stale; } rsp_t;
   rsp_t rq[$];

   int errors = 0, checks = 0;
   int gnt_pct, rv_pct, rdy_pct, fen_pct, br_pct;
   int total_pops = 0;
   logic [31:0] exp_faddr, exp_oaddr, prev_addr;
   int fifo_cnt;
   bit pending, prev_hold;
   logic o_req, o_grant, o_pop, o_valid;
   logic [31:0] o_iaddr, o_paddr;

   function automatic logic [31:0] memfn(logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
   endfunction

   function automatic logic errfn(logic [31:0] a);
      return (a[5:2] == 4'd2);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic do_reset(logic [31:0] boot);
      rst_i = 1'b1; boot_addr_i = boot; fetch_en_i = 1'b1; branch_i = 1'b0;
      branch_addr_i = '0; ready_i = 1'b0; instr_gnt_i = 1'b0;
      instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req", instr_req_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_addr", addr_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_iaddr", instr_addr_o, boot & 32'hFFFF_FFFC);
      rst_i = 1'b0;
      rq.delete();
      exp_faddr = boot & 32'hFFFF_FFFC;
      exp_oaddr = boot & 32'hFFFF_FFFC;
      fifo_cnt = 0; pending = 0; prev_hold = 0;
   endtask

   // One bus cycle: drive, sample, check against the stream model, advance.
   task automatic cycle();
      rsp_t f;
      bit rv, nonstale, pushm, popm;
      logic ev;
      logic [31:0] tgt;
      fetch_en_i  = ($urandom_range(1, 100) <= fen_pct);
      ready_i     = ($urandom_range(1, 100) <= rdy_pct);
      instr_gnt_i = ($urandom_range(1, 100) <= gnt_pct);
      rv = (rq.size() > 0) && ($urandom_range(1, 100) <= rv_pct);
      instr_rvalid_i = rv;
      if (rv) begin
         instr_rdata_i = memfn(rq[0].addr);
         instr_err_i   = errfn(rq[0].addr);
      end else begin
         instr_rdata_i = $urandom;
         instr_err_i   = 1'($urandom_range(0, 1));
      end
      if (!branch_i && br_pct > 0 && $urandom_range(1, 100) <= br_pct) begin
         branch_i = 1'b1;
         branch_addr_i = $urandom & 32'h0000_FFFF;
      end
      #1;
      o_req = instr_req_o; o_iaddr = instr_addr_o; o_valid = valid_o;
      o_grant = instr_req_o && instr_gnt_i;
      o_pop = valid_o && ready_i && !branch_i;
      o_paddr = addr_o;
      nonstale = 0;
      if (rv) nonstale = !rq[0].stale;

      if (prev_hold) begin
         chk("hold_req", instr_req_o, 1);
         chk("hold_addr", instr_addr_o, prev_addr);
      end
      ev = (fifo_cnt > 0) || (BYP && nonstale && !branch_i);
      chk("valid", valid_o, ev);
      if (o_pop) begin
         chk("out_addr", addr_o, exp_oaddr);
         chk("out_rdata", rdata_o, memfn(exp_oaddr));
         chk("out_err", err_o, errfn(exp_oaddr));
         exp_oaddr += 32'd4;
         total_pops++;
      end
      if (rv) f = rq.pop_front();
      if (o_grant) begin
         if (!pending) begin
            chk("grant_addr", instr_addr_o, exp_faddr);
            exp_faddr += 32'd4;
         end
         rq.push_back('{instr_addr_o, pending || branch_i});
         pending = 0;
      end
      pushm = nonstale && !branch_i && !(BYP && fifo_cnt == 0 && ready_i);
      popm  = (fifo_cnt > 0) && ready_i && !branch_i;
      fifo_cnt = fifo_cnt + int'(pushm) - int'(popm);
      if (branch_i) begin
         foreach (rq[i]) rq[i].stale = 1;
         tgt = branch_addr_i & 32'hFFFF_FFFC;
         exp_faddr = tgt; exp_oaddr = tgt; fifo_cnt = 0;
         if (o_req && !instr_gnt_i) pending = 1;
      end
      chk("outstanding_limit", 32'(rq.size() <= NUM_OUT), 1);
      chk("credit_limit", 32'(fifo_cnt + rq.size() <= DEPTH), 1);
      prev_hold = o_req && !instr_gnt_i;
      prev_addr = instr_addr_o;
      @(negedge clk);
      branch_i = 1'b0;
   endtask

   task automatic set_pct(int g, int r, int d, int fe, int b);
      gnt_pct = g; rv_pct = r; rdy_pct = d; fen_pct = fe; br_pct = b;
   endtask

   initial begin
      int n, m;
      bit got;
      logic [31:0] first_addr;

      // Boot and sustained stream
      set_pct(100, 100, 100, 100, 0);
      do_reset(32'h0000_0082);
      cycle();
      chk("first_req", o_req, 1);
      chk("first_addr", o_iaddr, 32'h80);
      chk("first_valid", o_valid, 0);
      cycle();
      chk("boot_g1", o_iaddr, 32'h84);
      chk("lat_valid1", o_valid, BYP);
      cycle();
      chk("boot_g2", o_iaddr, 32'h88);
      chk("lat_valid2", o_valid, 1);
      chk("lat_addr2", o_paddr, BYP ? 32'h84 : 32'h80);
      n = 0;
      repeat (10) begin cycle(); n += int'(o_pop); end
      chk("throughput", n, 10);

      // Back-pressure
      do_reset(32'h0000_0080);
      set_pct(100, 100, 0, 100, 0);
      n = 0;
      repeat (12) begin cycle(); n += int'(o_grant); end
      chk("bp_grants", n, DEPTH);
      chk("bp_req_off", o_req, 0);
      set_pct(100, 100, 100, 100, 0);
      n = 0; m = 0;
      repeat (8) begin cycle(); n += int'(o_pop); m += int'(o_grant); end
      chk("bp_pops", n, 8);
      chk("bp_resume", 32'(m > 0), 1);

      // Redirect with two requests in flight
      set_pct(100, 0, 100, 100, 0);
      repeat (3) cycle();
      set_pct(100, 100, 100, 100, 0);
      branch_i = 1'b1; branch_addr_i = 32'h203;
      cycle();
      cycle();
      chk("br_valid_n1", o_valid, 0);
      chk("br_req_n1", o_req, 1);
      chk("br_addr_n1", o_iaddr, 32'h200);
      got = 0; first_addr = '0;
      for (int k = 0; k < 20 && !got; k++) begin
         cycle();
         if (o_pop) begin got = 1; first_addr = o_paddr; end
      end
      chk("br_got_out", got, 1);
      chk("br_first_out", first_addr, 32'h200);

      // Redirect while the request is stalled on grant
      do_reset(32'h0000_0080);
      set_pct(100, 100, 100, 100, 0);
      cycle();
      set_pct(0, 100, 100, 100, 0);
      cycle();
      cycle();
      branch_i = 1'b1; branch_addr_i = 32'h302;
      cycle();
      cycle();
      chk("stall_req", o_req, 1);
      chk("stall_addr", o_iaddr, 32'h84);
      set_pct(100, 100, 100, 100, 0);
      cycle();
      chk("stall_grant", o_grant, 1);
      chk("stall_gaddr", o_iaddr, 32'h84);
      cycle();
      chk("tgt_grant", o_grant, 1);
      chk("tgt_gaddr", o_iaddr, 32'h300);
      got = 0; first_addr = '0;
      for (int k = 0; k < 20 && !got; k++) begin
         cycle();
         if (o_pop) begin got = 1; first_addr = o_paddr; end
      end
      chk("stall_got_out", got, 1);
      chk("stall_first_out", first_addr, 32'h300);

      // Random traffic
      set_pct(70, 60, 70, 90, 3);
      repeat (1500) cycle();
      set_pct(80, 70, 20, 95, 2);
      repeat (1500) cycle();
      chk("liveness", 32'(total_pops > 200), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
